dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RV32i core: it services the load/store requests that the datapath issues. Each request carries an address, right-aligned store data, a write flag and a size (lb/lh). The block performs byte-lane alignment, applies a programmable number of wait states, and stalls the core through `suspend` until it completes. Storage is an internal word array, and the core consumes load data right-aligned.

## Interface
- `DEPTH_LOG2`, 10: log2 of the number of 32-bit words in the array.
- `WAIT`, 2: wait-state cycles per access, 0..15.

- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `req` input 1: request valid; sampled only in IDLE.
- `memwrite` input 1: 1 = store, 0 = load.
- `lb` input 1: byte access.
- `lh` input 1: halfword access. `lb`=`lh`=0 means word.
- `addr` input 32: byte address (datapath `aluout`).
- `wdata` input 32: store data, right-aligned and zero-extended.
- `readdata` output 32: load data, right-aligned, upper bits zero.
- `suspend` output 1: core stall.
- `ack` output 1: one-cycle completion pulse.
- `err` output 1: misaligned or illegal size; valid with `ack`.

## Operation
- **FSM states:** IDLE, WAIT, ACCESS, RESP.
- **IDLE:**
  - `req`=1 latches `addr`, `wdata`, `memwrite`, `lb`, `lh` at the clock edge.
  - Next state is WAIT if `WAIT`>0, else ACCESS.
  - `req`=0 stays in IDLE.
- **WAIT:**
  - A 4-bit down-counter loads `WAIT`-1 on entry and decrements each cycle.
  - Leaves for ACCESS when the counter reaches 0, so WAIT lasts exactly `WAIT` cycles.
- **ACCESS (one cycle):**
  - Word index is `addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so addresses alias.
  - Store: masked write at the clock edge ending ACCESS.
    - sb: lane `addr[1:0]` gets `wdata[7:0]`.
    - sh: lanes {2\*`addr[1]`+1, 2\*`addr[1]`} get `wdata[15:0]`.
    - sw: all four lanes.
    - Unselected lanes are unchanged.
  - Load: the word is shifted right by 8\*`addr[1:0]` for lb or 16\*`addr[1]` for lh, then zero-filled above bit 7 (lb) or bit 15 (lh). The result is registered into `readdata`.
  - Next state is RESP.
- **RESP (one cycle):**
  - `ack`=1.
  - `err` is valid.
  - `readdata` is valid for loads; stores leave `readdata` unchanged.
  - Next state is IDLE.
  - `req` is ignored in RESP.
- **Error conditions:**
  - lh with `addr[0]`=1.
  - Word access with `addr[1:0]`≠0.
  - `lb`=`lh`=1.
- **Error response:**
  - Same timing as a normal access.
  - No array write.
  - `readdata` is set to 0.
  - `err`=1 with `ack`.
- **`suspend`** = (IDLE & `req`) | WAIT | ACCESS. The IDLE term is combinational, so the core stalls in the request cycle. `suspend` is 0 in RESP so the core advances with the data.
- **`readdata` hold:** it holds its value between RESP cycles.
- **Reset values:** state IDLE, counter 0, `ack`=0, `err`=0, `readdata`=0, latched request fields 0. `suspend`=0 whenever `req`=0.
- **Array:** not reset; its contents are undefined until written.

## Timing
- **Accept:** request accepted at the edge ending cycle 0, in IDLE with `req`=1.
- **ACCESS:** occupies cycle `WAIT`+1.
- **`ack`:** high in cycle `WAIT`+2 only. With `WAIT`=2, ack is in cycle 4; with `WAIT`=0, in cycle 2.
- **`suspend`:** high in cycles 0..`WAIT`+1, low in the `ack` cycle.
- **Throughput:** minimum request spacing is `WAIT`+3 cycles. A `req` held high through RESP is accepted again in the following IDLE cycle.
- **Store visibility:** store data is visible to a load issued after the store's `ack`.
- **Reset mid-operation:** asserting `reset` in WAIT or ACCESS returns to IDLE immediately, with outputs at their reset values.
  - An in-flight store whose ACCESS edge has not occurred is dropped.
  - No `ack` is issued for the aborted request.
- **Input stability:** `addr`, `wdata` and the control inputs may change after the accept edge without effect, because they are latched.

## Test plan
- **Word store then load (`WAIT`=2):**
  - sw `addr`=0x10, `wdata`=0xDEADBEEF: `ack` in cycle 4, `err`=0, `suspend` high in cycles 0–3.
  - lw 0x10: `readdata`=0xDEADBEEF in the `ack` cycle.
- **Byte and half lanes:**
  - After sw 0x20=0x11223344, sb 0x21 with `wdata`=0x000000AA, then lw 0x20: 0x1122AA44.
  - lb 0x23: 0x00000011.
  - lh 0x22: 0x00001122.
- **Misaligned access:**
  - lw 0x06: `ack` with `err`=1 and `readdata`=0.
  - sh 0x21 with `wdata`=0xFFFF: `err`=1, and a following lw 0x20 returns the old word unchanged.
- **`WAIT`=0:** lw at cycle 0 gives `ack` in cycle 2. Holding `req` high gives the next accept in cycle 3 and `ack` in cycle 5.
- **Reset during WAIT:**
  - Pulse `reset` low in cycle 1 of sw 0x30=0x12345678.
  - Required: `ack` never asserts, `suspend`=0, `readdata`=0.
  - A following lw 0x30 returns the pre-existing contents, not 0x12345678.
- **Aliasing:** sw 0x1000_0040=0xCAFEF00D, then lw 0x40 with `DEPTH_LOG2`=10 returns 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32i core: latches a load/store request, inserts WAIT
// wait states, performs byte-lane alignment on an internal word array and acks once.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic        lb,
  input  logic        lh,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        suspend,
  output logic        ack,
  output logic        err
);

  // state    | meaning
  // S_IDLE   | waiting for req; request fields latched on accept
  // S_WAIT   | burning WAIT wait-state cycles on cnt_q
  // S_ACCESS | array read/write, readdata and err registered
  // S_RESP   | ack pulse, core released
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam int         NWORDS    = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        we_q, lb_q, lh_q;
  logic [31:0] readdata_q, readdata_d;
  logic        ack_q, err_q;

  logic [31:0] mem_q [0:NWORDS-1];

  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0] word;
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] wr_val;
  logic [3:0]  be;
  logic        bad;
  logic        unused_ok;

  // Upper address bits alias onto the array.
  assign idx       = addr_q[DEPTH_LOG2+1:2];
  assign unused_ok = ^addr_q[31:DEPTH_LOG2+2];
  assign word      = mem_q[idx];

  assign bad = (lb_q & lh_q)
             | (lh_q & addr_q[0])
             | (~lb_q & ~lh_q & (addr_q[1:0] != 2'b00));

  always_comb begin
    shamt    = 5'd0;
    load_val = word;
    wr_val   = wdata_q;
    be       = 4'b1111;
    if (lb_q) begin
      shamt  = {addr_q[1:0], 3'b000};
      wr_val = {4{wdata_q[7:0]}};
      be     = 4'b0001 << addr_q[1:0];
    end else if (lh_q) begin
      shamt  = {addr_q[1], 4'b0000};
      wr_val = {2{wdata_q[15:0]}};
      be     = addr_q[1] ? 4'b1100 : 4'b0011;
    end
    shifted = word >> shamt;
    if (lb_q)
      load_val = {24'b0, shifted[7:0]};
    else if (lh_q)
      load_val = {16'b0, shifted[15:0]};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    readdata_d = readdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = (WAIT > 0) ? S_WAIT : S_ACCESS;
          cnt_d   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0)
          state_d = S_ACCESS;
        else
          cnt_d = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (bad)
          readdata_d = 32'd0;
        else if (!we_q)
          readdata_d = load_val;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      lb_q       <= 1'b0;
      lh_q       <= 1'b0;
      readdata_q <= 32'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
      ack_q      <= (state_q == S_ACCESS);
      err_q      <= (state_q == S_ACCESS) & bad;
      if (state_q == S_IDLE && req) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        we_q    <= memwrite;
        lb_q    <= lb;
        lh_q    <= lh;
      end
    end
  end

  // Array is deliberately unreset; a reset before ACCESS leaves it untouched.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && we_q && !bad) begin
      for (int i = 0; i < 4; i++)
        if (be[i])
          mem_q[idx][8*i +: 8] <= wr_val[8*i +: 8];
    end
  end

  assign suspend  = ((state_q == S_IDLE) & req) | (state_q == S_WAIT) | (state_q == S_ACCESS);
  assign readdata = readdata_q;
  assign ack      = ack_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT=2, one with WAIT=0,
// sharing stimulus; sel picks which instance gets req and is observed.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_c, sel;
  logic        memwrite, lb, lh;
  logic [31:0] addr, wdata;
  logic        req0, req1;
  logic [31:0] rd0, rd1;
  logic        susp0, susp1, ack0, ack1, err0, err1;
  logic [31:0] rd_m;
  logic        susp_m, ack_m, err_m;

  int n_vec  = 0;
  int n_miss = 0;

  assign req0   = req_c & ~sel;
  assign req1   = req_c & sel;
  assign rd_m   = sel ? rd1 : rd0;
  assign susp_m = sel ? susp1 : susp0;
  assign ack_m  = sel ? ack1 : ack0;
  assign err_m  = sel ? err1 : err0;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT(2)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .memwrite(memwrite), .lb(lb), .lh(lh),
    .addr(addr), .wdata(wdata), .readdata(rd0), .suspend(susp0), .ack(ack0), .err(err0)
  );

  dmem_responder #(.DEPTH_LOG2(10), .WAIT(0)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .memwrite(memwrite), .lb(lb), .lh(lh),
    .addr(addr), .wdata(wdata), .readdata(rd1), .suspend(susp1), .ack(ack1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at posedge+1 in IDLE, ends at posedge+1 after the ack cycle.
  task automatic xact(input logic s, input logic w, input logic b, input logic h,
                      input logic [31:0] a, input logic [31:0] wd, input int wt,
                      output logic [31:0] rd, output logic er);
    int ackc;
    ackc = -1;
    rd   = '0;
    er   = 1'b0;
    sel = s; memwrite = w; lb = b; lh = h; addr = a; wdata = wd; req_c = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack_m) begin
        ackc = c;
        rd   = rd_m;
        er   = err_m;
        check_val("susp_in_ack", {31'b0, susp_m}, 32'd0);
        break;
      end
      check_val("susp_busy", {31'b0, susp_m}, 32'd1);
      @(posedge clk); #1;
      if (c == 0) begin
        req_c    = 1'b0;
        addr     = $urandom;
        wdata    = $urandom;
        memwrite = 1'($urandom);
        lb       = 1'($urandom);
        lh       = 1'($urandom);
      end
    end
    check_val("ack_cycle", 32'(ackc), 32'(wt + 2));
    @(posedge clk); #1;
  endtask

  task automatic st(input logic s, input logic b, input logic h, input logic [31:0] a,
                    input logic [31:0] wd, input logic exp_err, input int wt);
    logic [31:0] rd;
    logic        er;
    xact(s, 1'b1, b, h, a, wd, wt, rd, er);
    check_val("st_err", {31'b0, er}, {31'b0, exp_err});
  endtask

  task automatic ld(input logic s, input logic b, input logic h, input logic [31:0] a,
                    input logic [31:0] exp_rd, input logic exp_err, input int wt);
    logic [31:0] rd;
    logic        er;
    xact(s, 1'b0, b, h, a, 32'hFFFF_FFFF, wt, rd, er);
    check_val("ld_data", rd, exp_rd);
    check_val("ld_err", {31'b0, er}, {31'b0, exp_err});
  endtask

  initial begin
    reset = 1'b0; req_c = 1'b0; sel = 1'b0;
    memwrite = 1'b0; lb = 1'b0; lh = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    check_val("rst_ack", {31'b0, ack0}, 32'd0);
    check_val("rst_err", {31'b0, err0}, 32'd0);
    check_val("rst_rd", rd0, 32'd0);
    check_val("rst_susp", {31'b0, susp0}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // word store/load, WAIT=2
    st(1'b0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 2);
    ld(1'b0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 2);

    // byte / half lanes
    st(1'b0, 1'b0, 1'b0, 32'h20, 32'h11223344, 1'b0, 2);
    st(1'b0, 1'b1, 1'b0, 32'h21, 32'h000000AA, 1'b0, 2);
    @(negedge clk);
    check_val("rd_hold_after_st", rd0, 32'hDEADBEEF);
    @(posedge clk); #1;
    ld(1'b0, 1'b0, 1'b0, 32'h20, 32'h1122AA44, 1'b0, 2);
    ld(1'b0, 1'b1, 1'b0, 32'h23, 32'h00000011, 1'b0, 2);
    ld(1'b0, 1'b1, 1'b0, 32'h21, 32'h000000AA, 1'b0, 2);
    ld(1'b0, 1'b0, 1'b1, 32'h22, 32'h00001122, 1'b0, 2);
    ld(1'b0, 1'b0, 1'b1, 32'h20, 32'h0000AA44, 1'b0, 2);

    // errors
    ld(1'b0, 1'b0, 1'b0, 32'h06, 32'h0, 1'b1, 2);
    st(1'b0, 1'b0, 1'b1, 32'h21, 32'h0000FFFF, 1'b1, 2);
    ld(1'b0, 1'b0, 1'b0, 32'h20, 32'h1122AA44, 1'b0, 2);
    ld(1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 1'b1, 2);
    st(1'b0, 1'b0, 1'b1, 32'h22, 32'h0000BEEF, 1'b0, 2);
    ld(1'b0, 1'b0, 1'b0, 32'h20, 32'hBEEFAA44, 1'b0, 2);

    // reset during WAIT drops the store
    st(1'b0, 1'b0, 1'b0, 32'h30, 32'h55AA55AA, 1'b0, 2);
    ld(1'b0, 1'b0, 1'b0, 32'h30, 32'h55AA55AA, 1'b0, 2);
    sel = 1'b0; memwrite = 1'b1; lb = 1'b0; lh = 1'b0;
    addr = 32'h30; wdata = 32'h12345678; req_c = 1'b1;
    @(posedge clk); #1;
    req_c = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_val("abort_ack", {31'b0, ack0}, 32'd0);
    check_val("abort_susp", {31'b0, susp0}, 32'd0);
    check_val("abort_rd", rd0, 32'd0);
    check_val("abort_err", {31'b0, err0}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_val("abort_no_ack", {31'b0, ack0}, 32'd0);
    end
    @(posedge clk); #1;
    ld(1'b0, 1'b0, 1'b0, 32'h30, 32'h55AA55AA, 1'b0, 2);

    // aliasing
    st(1'b0, 1'b0, 1'b0, 32'h1000_0040, 32'hCAFEF00D, 1'b0, 2);
    ld(1'b0, 1'b0, 1'b0, 32'h40, 32'hCAFEF00D, 1'b0, 2);

    // WAIT=0 instance, then back-to-back with req held
    st(1'b1, 1'b0, 1'b0, 32'h08, 32'h0BADCAFE, 1'b0, 0);
    sel = 1'b1; memwrite = 1'b0; lb = 1'b0; lh = 1'b0; addr = 32'h08; req_c = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_val("b2b_ack", {31'b0, ack_m}, {31'b0, (c == 2 || c == 5)});
      check_val("b2b_susp", {31'b0, susp_m}, {31'b0, !(c == 2 || c == 5)});
      if (c == 2 || c == 5)
        check_val("b2b_rd", rd_m, 32'h0BADCAFE);
      @(posedge clk); #1;
    end
    req_c = 1'b0;
    @(negedge clk);
    check_val("b2b_idle_ack", {31'b0, ack_m}, 32'd0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
